ahb_slave_dphase: RTL and testbench
===================================

Name: ahb_slave_dphase

Overview:
- AHB-Lite slave front end that sits directly upstream of the RAM/ROM slave glue.
- Samples the address phase and registers it into the data phase.
- Decodes the region into `muxsel`, inserts ROM wait states, and sequences the two-cycle AHB ERROR response.
- Drives `haddr_q`/`hwrite_q`/`hprot_q`/`muxsel` into the glue, plus a one-cycle `acc_valid` that the top level uses to gate the glue's enables.

Parameters:
- `ROM_WAIT`, default 1: wait states inserted on a valid ROM read (0..15).
- `RAM_BASE`, default 8'hB0: `haddr[31:24]` value selecting RAM.
- `ROM_BASE`, default 8'hA0: `haddr[31:24]` value selecting ROM.

Ports:
- `hclk`  in  1  bus clock
- `hresetn`  in  1  asynchronous active-low reset
- `hsel`  in  1  slave select
- `haddr`  in  32  address-phase address
- `htrans`  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- `hwrite`  in  1  address-phase direction
- `hsize`  in  3  transfer size
- `hprot`  in  4  protection
- `hready_in`  in  1  bus HREADY (previous transfer complete)
- `haddr_q`  out  32  registered address to glue
- `hwrite_q`  out  1  registered direction
- `hprot_q`  out  4  registered protection
- `hsize_q`  out  3  registered size
- `muxsel`  out  1  0 = RAM, 1 = ROM (registered)
- `acc_valid`  out  1  one-cycle strobe: glue access completes this cycle
- `hready_out`  out  1  slave HREADYOUT
- `hresp_out`  out  1  slave HRESP (1 = ERROR)

Behaviour:
- Reset (async, `hresetn`=0): state IDLE; all `_q` regs, `muxsel`, `acc_valid`, `hresp_out` = 0; `hready_out` = 1; wait counter = 0. Reset mid-transfer abandons it with no strobe.
- Accept condition: `hsel` & `htrans[1]` & `hready_in`. On accept, capture `haddr`/`hwrite`/`hprot`/`hsize`.
  - `muxsel` = (`haddr[31:24]` == `ROM_BASE`).
- IDLE/BUSY `htrans` with `hsel`: no capture; state goes to or stays IDLE (`hready_out`=1, `hresp_out`=0, zero-wait OKAY).
- Error classification on accept:
  - unmapped region (neither base) -> error;
  - ROM with `hwrite`=1 -> error;
  - ROM with `hprot[0]`=1 -> error;
  - RAM accesses never error.
- States:
  - IDLE: `hready_out`=1, `hresp_out`=0, no strobe.
  - ACCESS: `hready_out`=1, `acc_valid`=1 for this single cycle.
  - WAIT: `hready_out`=0; counter loaded with `ROM_WAIT` on entry and decremented each cycle; at 1 go to ACCESS.
  - ERR1: `hready_out`=0, `hresp_out`=1.
  - ERR2: `hready_out`=1, `hresp_out`=1; `acc_valid` never asserted in error.
- Transitions on accept:
  - error -> ERR1;
  - ROM read with `ROM_WAIT`>0 -> WAIT;
  - otherwise -> ACCESS.
- From ACCESS or ERR2:
  - a new accept follows the same decode (back-to-back pipelining; captured regs update at the same edge);
  - else -> IDLE.
- ERR1 always -> ERR2.
- From WAIT: new address-phase inputs are ignored while `hready_out`=0, since `hready_in` is low.
- `_q` registers hold their value until the next accept (not cleared in IDLE).
- Latency: RAM access completes 1 cycle after the address phase; ROM access completes after 1+`ROM_WAIT` cycles; error completes after 2 cycles.

Optional Feature:
- Macro: `AHB_ALIGN_CHECK_EN`.
- Defined: accept with misaligned size is classified as error → ERR1/ERR2, no strobe.
  - `hsize`=1 with `haddr[0]`≠0;
  - `hsize`=2 with `haddr[1:0]`≠0;
  - `hsize`>2 (any address).
- Undefined: `hsize`/alignment is not checked; `hsize_q` is still registered.

Decomposition:
- Shared package `ahb_pkg` holds:
  - `htrans_e` enum;
  - `hresp` encodings;
  - `RAM_BASE`/`ROM_BASE` default constants;
  - `dphase_state_e` (IDLE, ACCESS, WAIT, ERR1, ERR2).
- Optional sub-module `ahb_region_decode`: combinational region/error classification, reused by the top-level address decoder.

Test Plan:
- RAM write: NONSEQ `haddr`=32'hB000_0010, `hwrite`=1 -> next cycle `muxsel`=0, `haddr_q`=32'hB000_0010, `acc_valid`=1, `hready_out`=1, `hresp_out`=0.
- ROM read, `ROM_WAIT`=2: NONSEQ 32'hA000_0004, `hwrite`=0, `hprot`=4'b0010 -> `hready_out`=0 for 2 cycles, then `acc_valid`=1 with `muxsel`=1.
- ROM write 32'hA000_0000 -> cycle 1: `hready_out`=0, `hresp_out`=1; cycle 2: `hready_out`=1, `hresp_out`=1; `acc_valid` stays 0.
- Back-to-back: RAM reads at 32'hB000_0000 then 32'hB000_0004 on consecutive cycles -> `acc_valid` high 2 consecutive cycles with `haddr_q` updating each cycle.
- Unmapped 32'hC000_0000, then IDLE `htrans` -> ERR1, ERR2, then IDLE with `hready_out`=1, `hresp_out`=0.
- Reset asserted in WAIT -> `hready_out`=1, `acc_valid`=0, state IDLE immediately.
  - With `AHB_ALIGN_CHECK_EN`: `hsize`=2 at 32'hB000_0002 -> two-cycle error.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the data-phase slave front end.
// Holds transfer/response encodings, default region bases and the FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [7:0] RAM_BASE_DEF = 8'hB0;
  localparam logic [7:0] ROM_BASE_DEF = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } dphase_state_e;

endpackage

// File: rtl/ahb_slave_dphase_if.sv
// AHB-Lite address-phase and response signals seen by one slave.
interface ahb_slave_dphase_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hready_in;
  logic        hready_out;
  logic        hresp_out;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hready_in,
    input  hready_out, hresp_out
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hready_in,
    output hready_out, hresp_out
  );
endinterface

// File: rtl/ahb_region_decode.sv
// Combinational region and error classification of an address-phase transfer.
// Alignment checking is compiled in only when AHB_ALIGN_CHECK_EN is defined.
module ahb_region_decode
  import ahb_pkg::*;
#(
  parameter logic [7:0] RAM_BASE = RAM_BASE_DEF,
  parameter logic [7:0] ROM_BASE = ROM_BASE_DEF
) (
  input  logic [7:0] region,
  input  logic       hwrite,
  input  logic       hprot0,
`ifdef AHB_ALIGN_CHECK_EN
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
`endif
  output logic       is_rom,
  output logic       is_err
);

  logic is_ram;
  logic base_err;
  logic misaligned;

  // ROM is read-only and rejects data (hprot[0]) accesses; RAM never errors
  always_comb begin
    is_rom   = (region == ROM_BASE);
    is_ram   = (region == RAM_BASE);
    base_err = !(is_rom || is_ram) || (is_rom && (hwrite || hprot0));
  end

`ifdef AHB_ALIGN_CHECK_EN
  always_comb begin
    case (hsize)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = addr_lo[0];
      3'd2:    misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign is_err = base_err || misaligned;

endmodule

// File: rtl/ahb_slave_dphase.sv
// AHB-Lite slave data-phase sequencer: registers the address phase, inserts ROM
// wait states and drives the two-cycle ERROR response. Option: AHB_ALIGN_CHECK_EN.
module ahb_slave_dphase
  import ahb_pkg::*;
#(
  parameter int         ROM_WAIT = 1,
  parameter logic [7:0] RAM_BASE = RAM_BASE_DEF,
  parameter logic [7:0] ROM_BASE = ROM_BASE_DEF
) (
  input  logic                hclk,
  input  logic                hresetn,
  ahb_slave_dphase_if.slave   bus,
  output logic [31:0]         haddr_q,
  output logic                hwrite_q,
  output logic [3:0]          hprot_q,
  output logic [2:0]          hsize_q,
  output logic                muxsel,
  output logic                acc_valid
);

  dphase_state_e state;
  dphase_state_e state_nxt;
  dphase_state_e accept_state;
  logic [3:0]    wait_cnt;
  logic          can_accept;
  logic          trans_active;
  logic          accept;
  logic          is_rom;
  logic          is_err;

  ahb_region_decode #(
    .RAM_BASE (RAM_BASE),
    .ROM_BASE (ROM_BASE)
  ) u_decode (
    .region  (bus.haddr[31:24]),
    .hwrite  (bus.hwrite),
    .hprot0  (bus.hprot[0]),
`ifdef AHB_ALIGN_CHECK_EN
    .hsize   (bus.hsize),
    .addr_lo (bus.haddr[1:0]),
`endif
    .is_rom  (is_rom),
    .is_err  (is_err)
  );

  // A new address phase can only land while this slave is not stalling the bus
  always_comb begin
    trans_active = (htrans_e'(bus.htrans) inside {HT_NONSEQ, HT_SEQ});
    can_accept   = (state inside {ST_IDLE, ST_ACCESS, ST_ERR2});
    accept       = can_accept && bus.hsel && trans_active && bus.hready_in;
    if (is_err)
      accept_state = ST_ERR1;
    else if (is_rom && (ROM_WAIT > 0))
      accept_state = ST_WAIT;
    else
      accept_state = ST_ACCESS;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACCESS, ST_ERR2: state_nxt = accept ? accept_state : ST_IDLE;
      ST_WAIT:                     state_nxt = (wait_cnt <= 4'd1) ? ST_ACCESS : ST_WAIT;
      ST_ERR1:                     state_nxt = ST_ERR2;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Bus response and strobe are registered from the next state so they are glitch-free
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state          <= ST_IDLE;
      wait_cnt       <= 4'd0;
      haddr_q        <= 32'd0;
      hwrite_q       <= 1'b0;
      hprot_q        <= 4'd0;
      hsize_q        <= 3'd0;
      muxsel         <= 1'b0;
      acc_valid      <= 1'b0;
      bus.hready_out <= 1'b1;
      bus.hresp_out  <= HRESP_OKAY;
    end else begin
      state          <= state_nxt;
      acc_valid      <= (state_nxt == ST_ACCESS);
      bus.hready_out <= !(state_nxt inside {ST_WAIT, ST_ERR1});
      bus.hresp_out  <= (state_nxt inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
      if (state_nxt == ST_WAIT && state != ST_WAIT)
        wait_cnt <= 4'(ROM_WAIT);
      else if (state == ST_WAIT)
        wait_cnt <= wait_cnt - 4'd1;
      if (accept) begin
        haddr_q  <= bus.haddr;
        hwrite_q <= bus.hwrite;
        hprot_q  <= bus.hprot;
        hsize_q  <= bus.hsize;
        muxsel   <= is_rom;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_dphase.sv
// Self-checking bench for ahb_slave_dphase (ROM_WAIT=2) against a transaction-level
// response model; honours AHB_ALIGN_CHECK_EN when defined.
module tb_ahb_slave_dphase;

  localparam int ROM_WAIT = 2;

  typedef struct packed {
    logic rdy;
    logic resp;
    logic acc;
  } rsp_t;

  localparam rsp_t RSP_IDLE = '{rdy: 1'b1, resp: 1'b0, acc: 1'b0};
  localparam rsp_t RSP_WAIT = '{rdy: 1'b0, resp: 1'b0, acc: 1'b0};
  localparam rsp_t RSP_DONE = '{rdy: 1'b1, resp: 1'b0, acc: 1'b1};
  localparam rsp_t RSP_ERR1 = '{rdy: 1'b0, resp: 1'b1, acc: 1'b0};
  localparam rsp_t RSP_ERR2 = '{rdy: 1'b1, resp: 1'b1, acc: 1'b0};

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [3:0]  hprot_q;
  logic [2:0]  hsize_q;
  logic        muxsel;
  logic        acc_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  ahb_slave_dphase_if bus ();

  ahb_slave_dphase #(.ROM_WAIT(ROM_WAIT)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .bus       (bus),
    .haddr_q   (haddr_q),
    .hwrite_q  (hwrite_q),
    .hprot_q   (hprot_q),
    .hsize_q   (hsize_q),
    .muxsel    (muxsel),
    .acc_valid (acc_valid)
  );

  always #5 hclk = ~hclk;

  // Model: each accepted transfer schedules its whole response as a list of cycles
  rsp_t        pend[$];
  rsp_t        cur    = RSP_IDLE;
  logic [31:0] m_addr = '0;
  logic        m_write = 1'b0;
  logic [3:0]  m_prot = '0;
  logic [2:0]  m_size = '0;
  logic        m_rom = 1'b0;
  logic        m_err;
  logic        m_hit_rom;

`ifdef AHB_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    return (size == 3'd1 && lo[0]) || (size == 3'd2 && lo != 2'b00) || (size > 3'd2);
  endfunction
`endif

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pend.delete();
      cur     = RSP_IDLE;
      m_addr  = '0;
      m_write = 1'b0;
      m_prot  = '0;
      m_size  = '0;
      m_rom   = 1'b0;
    end else begin
      if (bus.hsel && bus.htrans[1] && bus.hready_in) begin
        m_hit_rom = (bus.haddr[31:24] == 8'hA0);
        m_err = !(m_hit_rom || bus.haddr[31:24] == 8'hB0) ||
                (m_hit_rom && (bus.hwrite || bus.hprot[0]))
`ifdef AHB_ALIGN_CHECK_EN
                || misaligned(bus.hsize, bus.haddr[1:0])
`endif
                ;
        pend.delete();
        if (m_err) begin
          pend.push_back(RSP_ERR1);
          pend.push_back(RSP_ERR2);
        end else begin
          if (m_hit_rom)
            for (int i = 0; i < ROM_WAIT; i++) pend.push_back(RSP_WAIT);
          pend.push_back(RSP_DONE);
        end
        m_addr  = bus.haddr;
        m_write = bus.hwrite;
        m_prot  = bus.hprot;
        m_size  = bus.hsize;
        m_rom   = m_hit_rom;
      end
      cur = (pend.size() > 0) ? pend.pop_front() : RSP_IDLE;
    end
  end

  // Every cycle: bus response, strobe and captured registers against the model
  always @(negedge hclk) begin
    if (cmp_en) begin
      n_cmp++;
      if ({bus.hready_out, bus.hresp_out, acc_valid, muxsel, haddr_q, hwrite_q, hprot_q, hsize_q} !==
          {cur.rdy, cur.resp, cur.acc, m_rom, m_addr, m_write, m_prot, m_size}) begin
        n_fail++;
        $display("[TB] FAIL model_cycle t=%0t: got rdy=%b resp=%b acc=%b mux=%b addr=%h wr=%b prot=%h size=%0d, want rdy=%b resp=%b acc=%b mux=%b addr=%h wr=%b prot=%h size=%0d",
                 $time, bus.hready_out, bus.hresp_out, acc_valid, muxsel, haddr_q, hwrite_q, hprot_q, hsize_q,
                 cur.rdy, cur.resp, cur.acc, m_rom, m_addr, m_write, m_prot, m_size);
      end
    end
  end

  // Drives one address-phase cycle; HREADY follows the model's expected response
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic write, input logic [2:0] size, input logic [3:0] prot,
                               input logic stall);
    @(posedge hclk);
    #2;
    bus.hsel      = sel;
    bus.htrans    = trans;
    bus.haddr     = addr;
    bus.hwrite    = write;
    bus.hsize     = size;
    bus.hprot     = prot;
    bus.hready_in = cur.rdy && !stall;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 2'b00, 32'h0, 1'b0, 3'd0, 4'h0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic rdy, input logic resp, input logic acc,
                             input logic mux, input logic [31:0] addr);
    n_cmp++;
    if ({bus.hready_out, bus.hresp_out, acc_valid, muxsel, haddr_q} !== {rdy, resp, acc, mux, addr}) begin
      n_fail++;
      $display("[TB] FAIL %s: got rdy=%b resp=%b acc=%b mux=%b addr=%h, want rdy=%b resp=%b acc=%b mux=%b addr=%h",
               name, bus.hready_out, bus.hresp_out, acc_valid, muxsel, haddr_q, rdy, resp, acc, mux, addr);
    end
  endtask

  initial begin
    hresetn       = 1'b0;
    bus.hsel      = 1'b0;
    bus.htrans    = 2'b00;
    bus.haddr     = 32'h0;
    bus.hwrite    = 1'b0;
    bus.hsize     = 3'd0;
    bus.hprot     = 4'h0;
    bus.hready_in = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge hclk);
    #2 checkOutput("reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    hresetn = 1'b1;

    $display("[TB] directed: RAM write");
    applyStimulus(1'b1, 2'b10, 32'hB000_0010, 1'b1, 3'd2, 4'h3, 1'b0);
    idleCycle();
    checkOutput("ram_write", 1'b1, 1'b0, 1'b1, 1'b0, 32'hB000_0010);
    idleCycle();
    checkOutput("ram_write_idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'hB000_0010);

    $display("[TB] directed: ROM read with wait states");
    applyStimulus(1'b1, 2'b10, 32'hA000_0004, 1'b0, 3'd2, 4'b0010, 1'b0);
    idleCycle();
    checkOutput("rom_wait1", 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0004);
    idleCycle();
    checkOutput("rom_wait2", 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0004);
    idleCycle();
    checkOutput("rom_done", 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0004);

    $display("[TB] directed: ROM write error");
    applyStimulus(1'b1, 2'b10, 32'hA000_0000, 1'b1, 3'd2, 4'h0, 1'b0);
    idleCycle();
    checkOutput("rom_wr_err1", 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0000);
    idleCycle();
    checkOutput("rom_wr_err2", 1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0000);
    idleCycle();
    checkOutput("rom_wr_after", 1'b1, 1'b0, 1'b0, 1'b1, 32'hA000_0000);

    $display("[TB] directed: back-to-back RAM reads");
    applyStimulus(1'b1, 2'b10, 32'hB000_0000, 1'b0, 3'd2, 4'h1, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'hB000_0004, 1'b0, 3'd2, 4'h1, 1'b0);
    checkOutput("b2b_first", 1'b1, 1'b0, 1'b1, 1'b0, 32'hB000_0000);
    idleCycle();
    checkOutput("b2b_second", 1'b1, 1'b0, 1'b1, 1'b0, 32'hB000_0004);

    $display("[TB] directed: unmapped region");
    applyStimulus(1'b1, 2'b10, 32'hC000_0000, 1'b0, 3'd0, 4'h0, 1'b0);
    idleCycle();
    checkOutput("unmapped_err1", 1'b0, 1'b1, 1'b0, 1'b0, 32'hC000_0000);
    idleCycle();
    checkOutput("unmapped_err2", 1'b1, 1'b1, 1'b0, 1'b0, 32'hC000_0000);
    idleCycle();
    checkOutput("unmapped_idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'hC000_0000);

`ifdef AHB_ALIGN_CHECK_EN
    $display("[TB] directed: misaligned word");
    applyStimulus(1'b1, 2'b10, 32'hB000_0002, 1'b0, 3'd2, 4'h0, 1'b0);
    idleCycle();
    checkOutput("align_err1", 1'b0, 1'b1, 1'b0, 1'b0, 32'hB000_0002);
    idleCycle();
    checkOutput("align_err2", 1'b1, 1'b1, 1'b0, 1'b0, 32'hB000_0002);
`endif

    $display("[TB] directed: reset during wait");
    applyStimulus(1'b1, 2'b10, 32'hA000_0008, 1'b0, 3'd2, 4'h0, 1'b0);
    idleCycle();
    checkOutput("pre_reset_wait", 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0008);
    #1 hresetn = 1'b0;
    #1 checkOutput("reset_in_wait", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge hclk);
    #2 hresetn = 1'b1;
    idleCycle();
    checkOutput("after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      logic [7:0]  region;
      logic [31:0] addr;
      case ($urandom_range(0, 3))
        0:       region = 8'hB0;
        1:       region = 8'hA0;
        2:       region = 8'hC0;
        default: region = 8'($urandom);
      endcase
      addr = {region, 24'($urandom)};
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom), addr, 1'($urandom),
                    3'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 7) == 0));
    end
    idleCycle();
    idleCycle();
    @(posedge hclk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
